// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: FSM encoding, common
// 2-input truth tables and the settle-timer width rule.
package gate_sweep_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SWEEP_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_SWEEP = SWEEP_ENC,
    ST_DONE  = DONE_ENC
  } sweep_state_t;

  // Truth tables: bit i is the expected output for input vector i (MSB = A).
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

  function automatic int unsigned timer_width(input int unsigned settle);
    return $clog2(settle) + 1;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that measures how long each vector is held before sampling.
// Loading takes priority; the counter parks at zero until reloaded.
module sweep_settle_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Counter register: reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep of a combinational gate: drives every input vector in order,
// compares the sampled output with TRUTH and reports count, first failure and pass.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned            N_IN   = 2,
  parameter int unsigned            SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = TT_XNOR2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            pass
);

  localparam int unsigned     NVEC     = 1 << N_IN;
  localparam int unsigned     TW       = timer_width(SETTLE);
  localparam logic [TW-1:0]   LOAD_VAL = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NVEC - 1);

  if (SETTLE < 1) begin : g_settle_illegal
    $fatal(1, "gate_sweep_ctrl: SETTLE must be at least 1");
  end

  sweep_state_t    r_state;
  logic [N_IN-1:0] r_idx;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_err_cnt;
  logic            r_ffv;
  logic [N_IN-1:0] r_ffi;
  logic            r_pass;

  logic            w_tmr_zero;
  logic            w_tmr_load;
  logic            w_sample;
  logic            w_mismatch;
  logic            w_last;
  logic [N_IN:0]   w_err_next;

  // Sample/advance decisions derived from the current state and settle timer.
  always_comb begin
    w_sample   = 1'b0;
    w_mismatch = 1'b0;
    w_last     = 1'b0;
    w_err_next = r_err_cnt;
    w_tmr_load = 1'b0;
    w_sample   = (r_state == ST_SWEEP) && w_tmr_zero;
    w_mismatch = w_sample && (y_in != TRUTH[r_idx]);
    w_last     = (r_idx == LAST_IDX);
    w_err_next = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};
    w_tmr_load = ((r_state == ST_IDLE) && start) || (w_sample && !w_last);
  end

  sweep_settle_timer #(
    .WIDTH (TW)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (LOAD_VAL),
    .o_zero     (w_tmr_zero)
  );

  // Sweep FSM with the vector index and all result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_cnt <= '0;
      r_ffv     <= 1'b0;
      r_ffi     <= '0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= ST_SWEEP;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_err_cnt <= '0;
            r_ffv     <= 1'b0;
            r_ffi     <= '0;
            r_pass    <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (w_sample) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && !r_ffv) begin
              r_ffv <= 1'b1;
              r_ffi <= r_idx;
            end
            // The terminal compare ends the sweep; the index never wraps.
            if (w_last) begin
              r_state <= ST_DONE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_idx <= r_idx + N_IN'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out        = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign first_fail_vld = r_ffv;
  assign first_fail_idx = r_ffi;
  assign pass           = r_pass;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) sweeping
// table-defined gates, checked cycle by cycle against a truth-table model.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] gate_a, gate_b;

  logic [1:0] vec_a, vec_b, ffi_a, ffi_b;
  logic [2:0] err_a, err_b;
  logic       y_a, y_b, busy_a, busy_b, done_a, done_b;
  logic       ffv_a, ffv_b, pass_a, pass_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y_a = gate_a[vec_a];
  assign y_b = gate_b[vec_b];

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .TRUTH(TT_XNOR2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .err_cnt(err_a), .first_fail_vld(ffv_a),
    .first_fail_idx(ffi_a), .pass(pass_a)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .TRUTH(TT_XNOR2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .err_cnt(err_b), .first_fail_vld(ffv_b),
    .first_fail_idx(ffi_b), .pass(pass_b)
  );

  // One full sweep on instance A or B; optionally re-pulses start mid-sweep and in DONE.
  task automatic sweep(input bit use_b, input logic [3:0] g, input bit repulse);
    logic [3:0] tt;
    int s, k, exp_err, exp_ffi, exp_vec;
    bit exp_ffv, exp_busy, exp_done, exp_pass;
    logic [1:0] o_vec, o_ffi;
    logic [2:0] o_err;
    logic o_busy, o_done, o_ffv, o_pass;
    tt = TT_XNOR2;
    s  = use_b ? 3 : 1;
    if (use_b) gate_b = g; else gate_a = g;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= 4*s + 5; n++) begin
      @(negedge clk);
      if (use_b) start_b = repulse && (n == 2 || n == 4*s + 1);
      else       start_a = repulse && (n == 2 || n == 4*s + 1);
      k = (n - 1) / s;
      if (k > 4) k = 4;
      exp_err = 0; exp_ffv = 1'b0; exp_ffi = 0;
      for (int i = 0; i < k; i++) begin
        if (g[i] != tt[i]) begin
          exp_err++;
          if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffi = i; end
        end
      end
      exp_busy = (n <= 4*s);
      exp_done = (n == 4*s + 1);
      exp_vec  = exp_busy ? (n - 1) / s : 0;
      exp_pass = (n > 4*s) && (exp_err == 0);
      o_vec  = use_b ? vec_b  : vec_a;
      o_busy = use_b ? busy_b : busy_a;
      o_done = use_b ? done_b : done_a;
      o_err  = use_b ? err_b  : err_a;
      o_ffv  = use_b ? ffv_b  : ffv_a;
      o_ffi  = use_b ? ffi_b  : ffi_a;
      o_pass = use_b ? pass_b : pass_a;
      checks += 7;
      if (o_vec !== 2'(exp_vec)) begin
        errors++; $display("FAIL vec_out inst=%0d gate=%b n=%0d got %0d expected %0d", use_b, g, n, o_vec, exp_vec);
      end
      if (o_busy !== exp_busy) begin
        errors++; $display("FAIL busy inst=%0d gate=%b n=%0d got %b expected %b", use_b, g, n, o_busy, exp_busy);
      end
      if (o_done !== exp_done) begin
        errors++; $display("FAIL done inst=%0d gate=%b n=%0d got %b expected %b", use_b, g, n, o_done, exp_done);
      end
      if (o_err !== 3'(exp_err)) begin
        errors++; $display("FAIL err_cnt inst=%0d gate=%b n=%0d got %0d expected %0d", use_b, g, n, o_err, exp_err);
      end
      if (o_ffv !== exp_ffv) begin
        errors++; $display("FAIL first_fail_vld inst=%0d gate=%b n=%0d got %b expected %b", use_b, g, n, o_ffv, exp_ffv);
      end
      if (o_ffi !== 2'(exp_ffi)) begin
        errors++; $display("FAIL first_fail_idx inst=%0d gate=%b n=%0d got %0d expected %0d", use_b, g, n, o_ffi, exp_ffi);
      end
      if (o_pass !== exp_pass) begin
        errors++; $display("FAIL pass inst=%0d gate=%b n=%0d got %b expected %b", use_b, g, n, o_pass, exp_pass);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if ({vec_a, busy_a, done_a, err_a, ffv_a, ffi_a, pass_a} !== 11'd0) begin
      errors++; $display("FAIL reset_a got %b expected all zero", {vec_a, busy_a, done_a, err_a, ffv_a, ffi_a, pass_a});
    end
    if ({vec_b, busy_b, done_b, err_b, ffv_b, ffi_b, pass_b} !== 11'd0) begin
      errors++; $display("FAIL reset_b got %b expected all zero", {vec_b, busy_b, done_b, err_b, ffv_b, ffi_b, pass_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_xnor();        sweep(1'b0, TT_XNOR2, 1'b0); endtask
  task automatic test_and();         sweep(1'b0, TT_AND2,  1'b0); endtask
  task automatic test_xor();         sweep(1'b0, TT_XOR2,  1'b0); endtask
  task automatic test_settle3();     sweep(1'b1, TT_XNOR2, 1'b0); endtask
  task automatic test_back_to_back();
    sweep(1'b0, TT_AND2, 1'b1);
    sweep(1'b1, TT_OR2,  1'b1);
  endtask

  task automatic test_abort();
    gate_a = TT_XNOR2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (vec_a !== 2'd2) begin
      errors++; $display("FAIL abort_setup vec_out got %0d expected 2", vec_a);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_a, busy_a, done_a, err_a, ffv_a, ffi_a, pass_a} !== 11'd0) begin
      errors++; $display("FAIL abort_async got %b expected all zero", {vec_a, busy_a, done_a, err_a, ffv_a, ffi_a, pass_a});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({done_a, busy_a} !== 2'b00) begin
        errors++; $display("FAIL abort_hold cycle=%0d done/busy got %b expected 00", i, {done_a, busy_a});
      end
    end
    rst_n = 1'b1;
    sweep(1'b0, TT_XNOR2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      sweep(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    gate_a  = TT_XNOR2;
    gate_b  = TT_XNOR2;
    test_reset();
    test_xnor();
    test_and();
    test_xor();
    test_settle3();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
